// File: rtl/acc_mem_bridge_pkg.sv
// Shared types and constants for the accelerator/host memory bridge.
package acc_bridge_pkg;

    localparam int ACC_ADDR_WID = 8;
    localparam int ACC_DATA_WID = 32;
    localparam int WORD_BYTES   = 4;
    localparam int WORD_SHIFT   = $clog2(WORD_BYTES);

    // IDLE: waiting | RD_FETCH: RAM read issued | RD_RESP: read_ready pulse | RD_WAIT: await finish_read
    // WR_COMMIT: RAM write + write_ready pulse | WR_WAIT: await finish_write | HOST: host access completes
    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_RESP,
        RD_WAIT,
        WR_COMMIT,
        WR_WAIT,
        HOST
    } bridge_state_t;

    // A byte offset from base_addr addresses a word only when aligned and inside the memory.
    function automatic logic word_ok(input logic [63:0] off, input int aw);
        return (off[WORD_SHIFT-1:0] == '0) && ((off >> (aw + WORD_SHIFT)) == 64'd0);
    endfunction

endpackage

// File: rtl/acc_mem_bridge_if.sv
// Accelerator session and host access signals of the memory bridge.
interface acc_mem_bridge_if
    import acc_bridge_pkg::*;
#(
    parameter int ADDR_WID = ACC_ADDR_WID,
    parameter int DATA_WID = ACC_DATA_WID
);
    logic [63:0]         base_addr;
    logic                read_enable;
    logic [63:0]         read_addr;
    logic                finish_read;
    logic [63:0]         read_ready;
    logic [DATA_WID-1:0] read_data;
    logic                write_enable;
    logic [63:0]         write_addr;
    logic [DATA_WID-1:0] write_data;
    logic                finish_write;
    logic [63:0]         write_ready;
    logic                host_en;
    logic                host_we;
    logic [ADDR_WID-1:0] host_addr;
    logic [DATA_WID-1:0] host_wdata;
    logic [DATA_WID-1:0] host_rdata;
    logic                host_ack;
    logic                err;

    modport master (
        output base_addr, read_enable, read_addr, finish_read,
        output write_enable, write_addr, write_data, finish_write,
        output host_en, host_we, host_addr, host_wdata,
        input  read_ready, read_data, write_ready, host_rdata, host_ack, err
    );

    modport slave (
        input  base_addr, read_enable, read_addr, finish_read,
        input  write_enable, write_addr, write_data, finish_write,
        input  host_en, host_we, host_addr, host_wdata,
        output read_ready, read_data, write_ready, host_rdata, host_ack, err
    );
endinterface

// File: rtl/acc_mem_bridge_sram.sv
// Single-port word RAM with one-cycle registered read; rdata holds between reads.
module acc_bridge_sram #(
    parameter int ADDR_WID = 8,
    parameter int DATA_WID = 32
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [ADDR_WID-1:0] addr,
    input  logic [DATA_WID-1:0] wdata,
    output logic [DATA_WID-1:0] rdata
);
    logic [DATA_WID-1:0] mem [2**ADDR_WID];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/acc_mem_bridge.sv
// Bridges accelerator byte-addressed read/write sessions and host word accesses onto one RAM.
// Optional ACC_MEM_BRIDGE_STATS_EN adds saturating rd_count/wr_count pulse counters.
module acc_mem_bridge
    import acc_bridge_pkg::*;
#(
    parameter int ADDR_WID = ACC_ADDR_WID,
    parameter int DATA_WID = ACC_DATA_WID
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ACC_MEM_BRIDGE_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
`endif
    acc_mem_bridge_if.slave bus
);
    bridge_state_t state, state_nxt;
    logic rd_load, wr_load, host_load;

    logic [63:0]         rd_off, wr_off;
    logic [ADDR_WID-1:0] rd_idx_q, wr_idx_q;
    logic                rd_ok_q, wr_ok_q, host_we_q;
    logic [DATA_WID-1:0] wr_data_q;
    logic [DATA_WID-1:0] read_data_q, host_rdata_q, rd_resp;
    logic                err_q;

    logic                sram_en, sram_we;
    logic [ADDR_WID-1:0] sram_addr;
    logic [DATA_WID-1:0] sram_wdata, sram_rdata;

    assign rd_off = bus.read_addr - bus.base_addr;
    assign wr_off = bus.write_addr - bus.base_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_load   = 1'b0;
        wr_load   = 1'b0;
        host_load = 1'b0;
        case (state)
            IDLE: begin
                if (bus.read_enable) begin
                    state_nxt = RD_FETCH;
                    rd_load   = 1'b1;
                end else if (bus.write_enable) begin
                    state_nxt = WR_COMMIT;
                    wr_load   = 1'b1;
                end else if (bus.host_en) begin
                    state_nxt = HOST;
                    host_load = 1'b1;
                end
            end
            RD_FETCH:  state_nxt = RD_RESP;
            RD_RESP:   state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (bus.finish_read) begin
                    state_nxt = RD_FETCH;
                    rd_load   = 1'b1;
                end else if (!bus.read_enable) begin
                    state_nxt = IDLE;
                end
            end
            WR_COMMIT: state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (bus.finish_write) begin
                    state_nxt = WR_COMMIT;
                    wr_load   = 1'b1;
                end else if (!bus.write_enable) begin
                    state_nxt = IDLE;
                end
            end
            HOST:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // The host access is issued from IDLE so its read data lines up with host_ack in HOST.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (state == RD_FETCH) begin
            sram_en   = 1'b1;
            sram_addr = rd_idx_q;
        end else if (state == WR_COMMIT) begin
            sram_en    = wr_ok_q;
            sram_we    = 1'b1;
            sram_addr  = wr_idx_q;
            sram_wdata = wr_data_q;
        end else if (host_load) begin
            sram_en    = 1'b1;
            sram_we    = bus.host_we;
            sram_addr  = bus.host_addr;
            sram_wdata = bus.host_wdata;
        end
    end

    acc_bridge_sram #(
        .ADDR_WID (ADDR_WID),
        .DATA_WID (DATA_WID)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en & reset),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    assign rd_resp = rd_ok_q ? sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_idx_q     <= '0;
            rd_ok_q      <= 1'b0;
            wr_idx_q     <= '0;
            wr_ok_q      <= 1'b0;
            wr_data_q    <= '0;
            host_we_q    <= 1'b0;
            read_data_q  <= '0;
            host_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            if (rd_load) begin
                rd_idx_q <= rd_off[ADDR_WID+WORD_SHIFT-1:WORD_SHIFT];
                rd_ok_q  <= word_ok(rd_off, ADDR_WID);
            end
            if (wr_load) begin
                wr_idx_q  <= wr_off[ADDR_WID+WORD_SHIFT-1:WORD_SHIFT];
                wr_ok_q   <= word_ok(wr_off, ADDR_WID);
                wr_data_q <= bus.write_data;
            end
            if (host_load) begin
                host_we_q <= bus.host_we;
            end
            if (state == RD_RESP) begin
                read_data_q <= rd_resp;
                if (!rd_ok_q) begin
                    err_q <= 1'b1;
                end
            end
            if (state == WR_COMMIT && !wr_ok_q) begin
                err_q <= 1'b1;
            end
            if (state == HOST && !host_we_q) begin
                host_rdata_q <= sram_rdata;
            end
        end
    end

    // Responses appear straight from the RAM during their pulse and are held afterwards.
    assign bus.read_ready  = {63'd0, state == RD_RESP};
    assign bus.write_ready = {63'd0, state == WR_COMMIT};
    assign bus.read_data   = (state == RD_RESP) ? rd_resp : read_data_q;
    assign bus.host_ack    = (state == HOST);
    assign bus.host_rdata  = (state == HOST && !host_we_q) ? sram_rdata : host_rdata_q;
    assign bus.err         = err_q;

`ifdef ACC_MEM_BRIDGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (state == RD_RESP && rd_count != 32'hFFFF_FFFF) begin
                rd_count <= rd_count + 32'd1;
            end
            if (state == WR_COMMIT && wr_count != 32'hFFFF_FFFF) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_acc_mem_bridge.sv
// Self-checking bench for acc_mem_bridge against a word-array reference model.
module tb_acc_mem_bridge;
    import acc_bridge_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    acc_mem_bridge_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus();

`ifdef ACC_MEM_BRIDGE_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    acc_mem_bridge #(.ADDR_WID(AW), .DATA_WID(DW)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef ACC_MEM_BRIDGE_STATS_EN
        .rd_count (rd_count),
        .wr_count (wr_count),
`endif
        .bus      (bus)
    );

    int total = 0;
    int bad = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    logic [31:0] mem_m [256];
    logic        err_m = 1'b0;
    logic [63:0] base;

    always @(negedge clk) begin
        if (bus.read_ready == 64'd1) rd_pulses++;
        if (bus.write_ready == 64'd1) wr_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit addr_valid(input logic [63:0] a);
        logic [63:0] off;
        off = a - base;
        return (off % 4 == 0) && (off / 4 < 256);
    endfunction

    function automatic int addr_index(input logic [63:0] a);
        logic [63:0] off;
        off = (a - base) / 4;
        return int'(off[7:0]);
    endfunction

    task automatic model_read(input logic [63:0] a, output logic [31:0] d);
        if (addr_valid(a)) begin
            d = mem_m[addr_index(a)];
        end else begin
            d = '0;
            err_m = 1'b1;
        end
    endtask

    task automatic model_write(input logic [63:0] a, input logic [31:0] d);
        if (addr_valid(a)) mem_m[addr_index(a)] = d;
        else err_m = 1'b1;
    endtask

    task automatic host_write(input int idx, input logic [31:0] d);
        bus.host_en = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = idx[7:0]; bus.host_wdata = d;
        tick;
        check("host_wr_ack", bus.host_ack, 1);
        bus.host_en = 1'b0; bus.host_we = 1'b0;
        mem_m[idx] = d;
        tick;
        check("host_ack_single", bus.host_ack, 0);
    endtask

    task automatic host_read(input int idx);
        bus.host_en = 1'b1; bus.host_we = 1'b0; bus.host_addr = idx[7:0];
        tick;
        check("host_rd_ack", bus.host_ack, 1);
        check("host_rdata", bus.host_rdata, mem_m[idx]);
        bus.host_en = 1'b0;
        tick;
    endtask

    // Shared tail of a read: fetch cycle, response pulse, then single-cycle check.
    task automatic rd_tail(input logic [63:0] a);
        logic [31:0] d;
        check("rd_lat_fetch", bus.read_ready, 0);
        check("wr_quiet_rd", bus.write_ready, 0);
        tick;
        model_read(a, d);
        check("rd_pulse", bus.read_ready, 1);
        check("rd_data", bus.read_data, d);
        tick;
        check("rd_single", bus.read_ready, 0);
        check("rd_data_hold", bus.read_data, d);
        check("err_rd", bus.err, err_m);
    endtask

    task automatic rd_first(input logic [63:0] a);
        bus.read_enable = 1'b1; bus.read_addr = a;
        tick;
        bus.read_addr = {$urandom, $urandom};
        rd_tail(a);
    endtask

    task automatic rd_next(input logic [63:0] a, input int gap);
        repeat (gap) begin
            tick;
            check("rd_wait_quiet", bus.read_ready, 0);
        end
        bus.finish_read = 1'b1; bus.read_addr = a;
        tick;
        bus.finish_read = 1'b0; bus.read_addr = {$urandom, $urandom};
        rd_tail(a);
    endtask

    task automatic rd_end;
        bus.read_enable = 1'b0;
        tick;
    endtask

    task automatic wr_tail(input logic [63:0] a, input logic [31:0] d);
        check("wr_pulse", bus.write_ready, 1);
        model_write(a, d);
        bus.write_addr = {$urandom, $urandom}; bus.write_data = $urandom;
        tick;
        check("wr_single", bus.write_ready, 0);
        check("err_wr", bus.err, err_m);
    endtask

    task automatic wr_first(input logic [63:0] a, input logic [31:0] d);
        bus.write_enable = 1'b1; bus.write_addr = a; bus.write_data = d;
        tick;
        wr_tail(a, d);
    endtask

    task automatic wr_next(input logic [63:0] a, input logic [31:0] d, input int gap);
        repeat (gap) tick;
        bus.finish_write = 1'b1; bus.write_addr = a; bus.write_data = d;
        tick;
        bus.finish_write = 1'b0;
        wr_tail(a, d);
    endtask

    task automatic wr_end;
        bus.write_enable = 1'b0;
        tick;
    endtask

    function automatic logic [63:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return {$urandom, $urandom};
        if (r == 1) return base + 64'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
        return base + 64'(4 * $urandom_range(0, 255));
    endfunction

    initial begin
        int rp, wp, n;
        logic [31:0] d0;
        bus.base_addr = '0; bus.read_enable = 1'b0; bus.read_addr = '0; bus.finish_read = 1'b0;
        bus.write_enable = 1'b0; bus.write_addr = '0; bus.write_data = '0; bus.finish_write = 1'b0;
        bus.host_en = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        base = 64'h1000;
        bus.base_addr = base;

        repeat (2) tick;
        check("rst_read_ready", bus.read_ready, 0);
        check("rst_write_ready", bus.write_ready, 0);
        check("rst_host_ack", bus.host_ack, 0);
        check("rst_read_data", bus.read_data, 0);
        check("rst_host_rdata", bus.host_rdata, 0);
        check("rst_err", bus.err, 0);
`ifdef ACC_MEM_BRIDGE_STATS_EN
        check("rst_rd_count", rd_count, 0);
        check("rst_wr_count", wr_count, 0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 256; i++) host_write(i, $urandom);

        // Host-loaded words read back through a session at base 0x1000.
        host_write(0, 32'h1111_1111);
        host_write(1, 32'h2222_2222);
        host_write(2, 32'h3333_3333);
        host_write(3, 32'h4444_4444);
        rp = rd_pulses;
        rd_first(64'h1000);
        rd_next(64'h1004, 0);
        rd_next(64'h1008, 1);
        rd_next(64'h100C, 2);
        check("rd_last_word", bus.read_data, 32'h4444_4444);
        rd_end;
        check("rd_pulse_count", rd_pulses - rp, 4);

        wp = wr_pulses;
        wr_first(base + 64'h40, 32'hA0);
        wr_next(base + 64'h44, 32'hA1, 1);
        wr_next(base + 64'h48, 32'hA2, 0);
        wr_end;
        check("wr_pulse_count", wr_pulses - wp, 3);
        host_read(16);
        host_read(17);
        host_read(18);
        check("host_rd_a2", bus.host_rdata, 32'hA2);
`ifdef ACC_MEM_BRIDGE_STATS_EN
        check("stat_rd_count", rd_count, 4);
        check("stat_wr_count", wr_count, 3);
`endif

        // Out-of-range and misaligned addresses.
        check("err_clear_before", bus.err, 0);
        rd_first(base - 64'd4);
        check("err_below_base", bus.err, 1);
        rd_next(base + 64'h402, 0);
        rd_next(base + 64'h8, 0);
        rd_end;
        check("err_sticky", bus.err, 1);
        wr_first(base + 64'h400, $urandom);
        wr_end;
        host_read(0);

        // Read and write sessions requested together: read completes first.
        wp = wr_pulses;
        bus.read_enable = 1'b1; bus.read_addr = base + 64'h20;
        bus.write_enable = 1'b1; bus.write_addr = base + 64'h24; bus.write_data = 32'hC0FFEE;
        tick;
        rd_tail(base + 64'h20);
        rd_next(base + 64'h28, 1);
        repeat (2) begin
            tick;
            check("wr_held_off", bus.write_ready, 0);
        end
        bus.read_enable = 1'b0;
        tick;
        check("wr_after_rd_idle", bus.write_ready, 0);
        check("wr_none_yet", wr_pulses - wp, 0);
        tick;
        wr_tail(base + 64'h24, 32'hC0FFEE);
        wr_end;
        host_read(9);

        for (int s = 0; s < 5; s++) begin
            base = {$urandom, $urandom} & ~64'h3;
            bus.base_addr = base;
            n = $urandom_range(2, 4);
            for (int i = 0; i < n; i++) begin
                if (i == 0) wr_first(pick_addr(), $urandom);
                else wr_next(pick_addr(), $urandom, $urandom_range(0, 2));
            end
            wr_end;
            for (int i = 0; i < n; i++) begin
                if (i == 0) rd_first(pick_addr());
                else rd_next(pick_addr(), $urandom_range(0, 2));
            end
            rd_end;
        end

        // Reset while waiting in a read session.
        base = 64'h1000;
        bus.base_addr = base;
        rd_first(base + 64'h8);
        d0 = 32'h0;
        reset = 1'b0; bus.finish_read = 1'b1;
        tick;
        err_m = 1'b0;
        check("rst_mid_ready", bus.read_ready, 0);
        check("rst_mid_data", bus.read_data, d0);
        check("rst_mid_err", bus.err, 0);
        reset = 1'b1; bus.finish_read = 1'b0; bus.read_enable = 1'b0;
        host_read(2);
        host_read(16);
        host_read($urandom_range(0, 255));
`ifdef ACC_MEM_BRIDGE_STATS_EN
        check("rst_mid_rd_count", rd_count, 0);
        check("rst_mid_wr_count", wr_count, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
